sprite_rom_arbiter: RTL and testbench
=====================================

Name: sprite_rom_arbiter

Overview:
- Shares one single-port sprite ROM between NUM_REQ requesters, such as player, enemy and bomb renderers.
- The ROM has a 1-cycle registered read.
- Each requester asks for a burst of consecutive pixels, typically one sprite row.
- Round-robin arbitration grants one burst at a time. The arbiter drives ROM addresses, one per cycle, and returns tagged pixel data to the winner.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- ADDR_WIDTH, 14, ROM address width (32*48*9 pixels).
- DATA_WIDTH, 12, pixel width (RGB444).
- MAX_BURST, 32, maximum pixels per burst.
- LEN_WIDTH, $clog2(MAX_BURST+1), width of the burst length field (localparam).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request; held high until gnt.
- req_addr  in  NUM_REQ x ADDR_WIDTH  burst start address per requester.
- req_len  in  NUM_REQ x LEN_WIDTH  pixels requested, 0..MAX_BURST.
- gnt  out  NUM_REQ  one-hot, 1-cycle accept pulse.
- rsp_valid  out  NUM_REQ  one-hot; pixel for that requester is on rsp_data.
- rsp_last  out  1  qualifies the final pixel of the current burst.
- rsp_data  out  DATA_WIDTH  pixel data, shared by all requesters.
- rom_addr  out  ADDR_WIDTH  address to sprite ROM.
- rom_data  in  DATA_WIDTH  ROM read data, 1 cycle after rom_addr.
- busy  out  1  high while a burst is in flight, including the data-return cycle.

Behaviour:
Reset (asynchronous):
- gnt=0, rsp_valid=0, rsp_last=0, busy=0, rom_addr=0.
- RR pointer=0, state=IDLE, in-flight tag cleared.

States:
- IDLE:
  - Scan req starting at the pointer and wrapping; the first asserted index w wins.
  - gnt[w]=1 combinationally in this cycle.
  - At the clock edge, latch cur_addr=req_addr[w], remaining=max(req_len[w],1), owner=w.
  - Set pointer=(w+1) mod NUM_REQ and go to BURST.
  - If no req is asserted, stay in IDLE with the pointer unchanged.
- BURST:
  - rom_addr=cur_addr, registered.
  - Each cycle: cur_addr+=1 (wraps modulo 2^ADDR_WIDTH), remaining-=1.
  - When remaining reaches 1, the last address is issued and the next state is IDLE.
  - No arbitration takes place in BURST; gnt=0.

Data return:
- A 1-deep pipeline register carries {valid, owner, last} alongside each issued address.
- One cycle after address k is issued: rsp_valid[owner]=1, rsp_data=rom_data (combinational pass-through), rsp_last=1 only for the final address.
- rsp_valid is never asserted for more than one requester.

Latency and throughput:
- Accept at cycle T gives the first rsp_valid at T+2.
- A burst of L pixels occupies rsp_valid cycles T+2..T+L+1.
- Back-to-back bursts have one IDLE gap cycle between the last address and the next first address.

Other rules:
- busy is high from the cycle after gnt through the cycle carrying rsp_last.
- rom_addr holds its last value while IDLE.
- req_len=0 is treated as 1.
- req_len>MAX_BURST cannot be encoded when MAX_BURST+1 is a power of two. Otherwise it is clamped to MAX_BURST.
- Dropping req before gnt withdraws the request with no side effects.
- Requester inputs are ignored during BURST; values are sampled only at the accept edge.
- Reset mid-burst: everything returns to reset values immediately. No further rsp_valid occurs, and the pointer returns to 0.

Test Plan:
- Single burst: req[1]=1, addr=0x100, len=4; ROM holds addr-indexed data → gnt[1] pulses at T. rom_addr=0x100..0x103 at T+1..T+4. rsp_valid[1] at T+2..T+5, rsp_last at T+5, data matches ROM[0x100..0x103].
- Contention: req[0], req[2] and req[3] all high from reset, each len=2 → grant order 0, 2, 3. Each burst separated by one IDLE cycle; the pointer ends at 0.
- Fairness: all four requesters continuously requesting for 8 bursts → grant sequence 0,1,2,3,0,1,2,3. No rsp_valid overlap between requesters.
- Zero length: req[2], len=0, addr=0x055 → exactly one rsp_valid[2] with rsp_last=1 and data=ROM[0x055].
- Wrap: addr=0x3FFE, len=4 → rom_addr sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Reset mid-burst: len=16, rst_n low at the 5th data beat → all outputs 0 asynchronously. After release, with no req: busy stays 0 and no rsp_valid is asserted.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one single-port sprite ROM between NUM_REQ burst requesters.
// Addresses stream one per cycle; tagged pixels come back one cycle later on a shared bus.
module sprite_rom_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 12,
    parameter int MAX_BURST  = 32,
    localparam int LEN_WIDTH = $clog2(MAX_BURST + 1)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0][LEN_WIDTH-1:0]  req_len,
    output logic [NUM_REQ-1:0]                 gnt,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic                               rsp_last,
    output logic [DATA_WIDTH-1:0]              rsp_data,
    output logic [ADDR_WIDTH-1:0]              rom_addr,
    input  logic [DATA_WIDTH-1:0]              rom_data,
    output logic                               busy
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state;
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      owner;
    logic [PTR_W-1:0]      win;
    logic                  found;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  vld_p1;
    logic                  last_p1;
    logic [PTR_W-1:0]      owner_p1;

    // A zero-length request still fetches one pixel; oversize lengths saturate.
    function automatic logic [LEN_WIDTH-1:0] sat_len(input logic [LEN_WIDTH-1:0] len);
        if (len == '0)
            return LEN_WIDTH'(1);
        if (int'(len) > MAX_BURST)
            return LEN_WIDTH'(MAX_BURST);
        return len;
    endfunction

    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[PTR_W'((int'(ptr) + i) % NUM_REQ)]) begin
                found = 1'b1;
                win   = PTR_W'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (rst_n && state == IDLE && found)
            gnt[win] = 1'b1;
    end

    always_comb begin
        rsp_valid = '0;
        if (vld_p1)
            rsp_valid[owner_p1] = 1'b1;
    end

    assign rsp_last = last_p1;
    assign rsp_data = vld_p1 ? rom_data : '0;
    assign busy     = (state == BURST) || vld_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            rom_addr  <= '0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            owner_p1  <= '0;
        end else begin
            // p1: tag for the address on rom_addr now, aligned with rom_data next cycle
            vld_p1   <= (state == BURST);
            last_p1  <= (state == BURST) && (remaining == LEN_WIDTH'(1));
            owner_p1 <= owner;
            case (state)
                IDLE: begin
                    if (found) begin
                        rom_addr  <= req_addr[win];
                        cur_addr  <= req_addr[win] + 1'b1;
                        remaining <= sat_len(req_len[win]);
                        owner     <= win;
                        ptr       <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (remaining == LEN_WIDTH'(1)) begin
                        state <= IDLE;
                    end else begin
                        rom_addr  <= cur_addr;
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: a cycle-stamped transaction model predicts
// grants, ROM addresses and tagged pixel beats; a registered ROM model feeds rom_data.
module tb_sprite_rom_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int ADDR_WIDTH = 14;
    localparam int DATA_WIDTH = 12;
    localparam int MAX_BURST  = 32;
    localparam int LEN_WIDTH  = $clog2(MAX_BURST + 1);

    typedef struct {
        int                    cyc;
        int                    own;
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } beat_t;

    typedef struct {
        int                    cyc;
        logic [ADDR_WIDTH-1:0] addr;
    } addr_t;

    logic                               clk = 1'b0;
    logic                               rst_n;
    logic [NUM_REQ-1:0]                 req;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0][LEN_WIDTH-1:0]  req_len;
    logic [NUM_REQ-1:0]                 gnt;
    logic [NUM_REQ-1:0]                 rsp_valid;
    logic                               rsp_last;
    logic [DATA_WIDTH-1:0]              rsp_data;
    logic [ADDR_WIDTH-1:0]              rom_addr;
    logic [DATA_WIDTH-1:0]              rom_data;
    logic                               busy;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    n       = 0;
    int    n_beats = 0;
    int    m_ptr   = 0;
    int    m_free  = 0;
    int    busy_lo = 1;
    int    busy_hi = 0;
    int    want [NUM_REQ];
    beat_t rq [$];
    addr_t aq [$];
    int    glog [$];
    int    exp_cont [3] = '{0, 2, 3};
    int    exp_fair [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    sprite_rom_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_addr (req_addr),
        .req_len  (req_len),
        .gnt      (gnt),
        .rsp_valid(rsp_valid),
        .rsp_last (rsp_last),
        .rsp_data (rsp_data),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_WIDTH-1:0] rom_f(input logic [ADDR_WIDTH-1:0] a);
        return DATA_WIDTH'(a * 37) ^ DATA_WIDTH'(a >> 5);
    endfunction

    always @(posedge clk) rom_data <= rom_f(rom_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_gnt"}, 32'(gnt), 32'(0));
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
        check_eq({tag, "_rsp_last"}, 32'(rsp_last), 32'(0));
        check_eq({tag, "_busy"}, 32'(busy), 32'(0));
        check_eq({tag, "_rom_addr"}, 32'(rom_addr), 32'(0));
    endtask

    task automatic set_req(input int i, input logic [ADDR_WIDTH-1:0] a,
                           input logic [LEN_WIDTH-1:0] l, input int cnt);
        req_addr[i] = a;
        req_len[i]  = l;
        want[i]     = cnt;
        req[i]      = 1'b1;
    endtask

    // Checks one cycle at the falling edge, then applies request drops after the next rising edge.
    task automatic step();
        logic [NUM_REQ-1:0]    eg;
        logic [NUM_REQ-1:0]    ev;
        logic                  eb;
        logic [ADDR_WIDTH-1:0] a;
        int                    w;
        int                    len_eff;
        int                    drop;
        drop = -1;
        @(negedge clk);
        n++;
        eb = (n >= busy_lo) && (n <= busy_hi);
        check_eq("busy", 32'(busy), 32'(eb));
        eg = '0;
        w  = -1;
        if (n >= m_free) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (w < 0 && req[(m_ptr + i) % NUM_REQ]) w = (m_ptr + i) % NUM_REQ;
        end
        if (w >= 0) eg[w] = 1'b1;
        check_eq("gnt", 32'(gnt), 32'(eg));
        if (w >= 0) begin
            if (req_len[w] == 0) len_eff = 1;
            else if (int'(req_len[w]) > MAX_BURST) len_eff = MAX_BURST;
            else len_eff = int'(req_len[w]);
            a = req_addr[w];
            for (int k = 0; k < len_eff; k++) begin
                aq.push_back('{cyc: n + 1 + k, addr: a + ADDR_WIDTH'(k)});
                rq.push_back('{cyc: n + 2 + k, own: w, data: rom_f(a + ADDR_WIDTH'(k)),
                               last: (k == len_eff - 1)});
            end
            glog.push_back(w);
            m_ptr   = (w + 1) % NUM_REQ;
            m_free  = n + len_eff + 1;
            busy_lo = n + 1;
            busy_hi = n + len_eff + 1;
            want[w]--;
            if (want[w] <= 0) drop = w;
        end
        ev = '0;
        if (rq.size() > 0 && rq[0].cyc == n) ev[rq[0].own] = 1'b1;
        check_eq("rsp_valid", 32'(rsp_valid), 32'(ev));
        check_eq("rsp_onehot", 32'($onehot0(rsp_valid)), 32'(1));
        if (ev != 0) begin
            check_eq("rsp_data", 32'(rsp_data), 32'(rq[0].data));
            check_eq("rsp_last", 32'(rsp_last), 32'(rq[0].last));
            n_beats++;
            void'(rq.pop_front());
        end else begin
            check_eq("rsp_last_idle", 32'(rsp_last), 32'(0));
        end
        if (aq.size() > 0 && aq[0].cyc == n) begin
            check_eq("rom_addr", 32'(rom_addr), 32'(aq[0].addr));
            void'(aq.pop_front());
        end
        @(posedge clk);
        #1;
        if (drop >= 0) req[drop] = 1'b0;
    endtask

    function automatic bit pending();
        bit p;
        p = (rq.size() > 0) || (aq.size() > 0);
        for (int i = 0; i < NUM_REQ; i++)
            if (want[i] > 0) p = 1'b1;
        return p;
    endfunction

    task automatic run(input string tag, input int max_cyc);
        int k;
        k = 0;
        while (pending() && k < max_cyc) begin
            step();
            k++;
        end
        check_eq({tag, "_timeout"}, 32'(k < max_cyc), 32'(1));
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_addr = '0;
        req_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) want[i] = 0;

        // Contention: requests already pending while reset is held
        set_req(0, 14'h0010, 6'd2, 1);
        set_req(2, 14'h0020, 6'd2, 1);
        set_req(3, 14'h0030, 6'd2, 1);
        @(posedge clk);
        #1;
        check_reset("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        run("contention", 100);
        check_eq("cont_count", 32'(glog.size()), 32'(3));
        for (int i = 0; i < 3 && i < glog.size(); i++)
            check_eq("cont_order", 32'(glog[i]), 32'(exp_cont[i]));

        // Fairness: everyone keeps requesting for two bursts each
        glog.delete();
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, ADDR_WIDTH'(14'h0400 + i * 14'h0040), 6'd3, 2);
        run("fairness", 200);
        check_eq("fair_count", 32'(glog.size()), 32'(8));
        for (int i = 0; i < 8 && i < glog.size(); i++)
            check_eq("fair_order", 32'(glog[i]), 32'(exp_fair[i]));

        // Single burst
        n_beats = 0;
        set_req(1, 14'h0100, 6'd4, 1);
        run("single", 50);
        check_eq("single_beats", 32'(n_beats), 32'(4));

        // Zero length behaves as one pixel
        n_beats = 0;
        set_req(2, 14'h0055, 6'd0, 1);
        run("zero_len", 50);
        check_eq("zero_beats", 32'(n_beats), 32'(1));

        // Address wrap
        n_beats = 0;
        set_req(0, 14'h3FFE, 6'd4, 1);
        run("wrap", 50);
        check_eq("wrap_beats", 32'(n_beats), 32'(4));

        // Oversize length clamps to MAX_BURST
        n_beats = 0;
        set_req(3, 14'h0800, 6'd40, 1);
        run("clamp", 100);
        check_eq("clamp_beats", 32'(n_beats), 32'(MAX_BURST));

        // Withdrawn request and input changes during a burst have no effect
        glog.delete();
        set_req(0, 14'h0900, 6'd8, 1);
        step();
        req[1]      = 1'b1;
        req_addr[1] = 14'h0A00;
        req_len[1]  = 6'd3;
        repeat (3) step();
        req[1]      = 1'b0;
        req_addr[0] = 14'h1234;
        req_len[0]  = 6'd5;
        run("withdraw", 50);
        check_eq("withdraw_grants", 32'(glog.size()), 32'(1));

        // Reset in the middle of a long burst
        glog.delete();
        set_req(2, 14'h0200, 6'd16, 1);
        step();
        check_eq("rmb_granted", 32'(glog.size()), 32'(1));
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check_reset("rmb");
        rq.delete();
        aq.delete();
        m_ptr   = 0;
        m_free  = 0;
        busy_lo = 1;
        busy_hi = 0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (8) step();

        // Pointer is back at 0 after reset
        glog.delete();
        set_req(3, 14'h0300, 6'd2, 1);
        set_req(0, 14'h0310, 6'd2, 1);
        run("post_reset", 50);
        check_eq("post_count", 32'(glog.size()), 32'(2));
        if (glog.size() > 0) check_eq("post_first", 32'(glog[0]), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
